// File: rtl/rv32i_pkg.sv
// Shared architectural constants for the integer register file and scoreboard.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// Saturating in-flight writer counter for one architectural register.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt
);
  localparam logic signed [CNT_W+1:0] MAX_S = (CNT_W+2)'((2**CNT_W) - 1);

  logic signed [CNT_W+1:0] sum;
  logic [CNT_W-1:0]        nxt;

  // Net of all events in one step; two extra bits hold -2..MAX+1 before clamping.
  always_comb begin
    sum = $signed({2'b00, cnt})
        + $signed({{(CNT_W+1){1'b0}}, inc})
        - $signed({{(CNT_W+1){1'b0}}, dec_wb})
        - $signed({{(CNT_W+1){1'b0}}, dec_kill});
    nxt = sum[CNT_W-1:0];
    if (sum[CNT_W+1])  nxt = '0;
    else if (sum > MAX_S) nxt = MAX_S[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with writeback bypass and per-register in-flight
// writer counters that raise decode stall / full on RAW hazards.
module regfile_scoreboard
  import rv32i_pkg::*;
#(
  parameter int XW    = XLEN,
  parameter int NR    = NREG,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] A1D,
  input  logic [REG_ADDR_W-1:0] A2D,
  output logic [XW-1:0]         RD1D,
  output logic [XW-1:0]         RD2D,
  input  logic                  IssueD,
  input  logic                  RegWriteD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  KillE,
  input  logic [REG_ADDR_W-1:0] KillRdE,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XW-1:0]         ResultW,
  output logic                  StallD,
  output logic                  FullD
);
  logic [NR-1:0][XW-1:0]    rf;
  logic [NR-1:0][CNT_W-1:0] cnt;
  logic                     issue_ok;
  logic                     wb1, wb2, wbd, busy1, busy2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           rf <= '0;
    else if (RegWriteW && RdW != REG_ZERO) rf[RdW] <= ResultW;
  end

  assign cnt[0] = '0;

  generate
    for (genvar r = 1; r < NR; r++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (issue_ok && RdD == REG_ADDR_W'(r)),
        .dec_wb   (RegWriteW && RdW == REG_ADDR_W'(r)),
        .dec_kill (KillE && KillRdE == REG_ADDR_W'(r)),
        .cnt      (cnt[r])
      );
    end
  endgenerate

  // A retiring writer only clears the hazard when it is the last one pending.
  always_comb begin
    wb1   = RegWriteW && RdW == A1D;
    wb2   = RegWriteW && RdW == A2D;
    wbd   = RegWriteW && RdW == RdD;
    busy1 = A1D != REG_ZERO && cnt[A1D] > CNT_W'(wb1);
    busy2 = A2D != REG_ZERO && cnt[A2D] > CNT_W'(wb2);
    StallD = rst_n && (busy1 || busy2);
    FullD  = rst_n && RegWriteD && RdD != REG_ZERO && (&cnt[RdD]) && !wbd;
    issue_ok = IssueD && !StallD && !FullD && RegWriteD;

    RD1D = '0;
    if (rst_n && A1D != REG_ZERO) RD1D = wb1 ? ResultW : rf[A1D];
    RD2D = '0;
    if (rst_n && A2D != REG_ZERO) RD2D = wb2 ? ResultW : rf[A2D];
  end
endmodule
